// File: rtl/calc1_unit_if.sv
// calc1_unit_if: requester-side bus of the four-port calculator.
// Per-port command/operand inputs and response code/result outputs,
// all big-endian ([0:W-1], bit 0 = MSB).
interface calc1_unit_if #(
  parameter int DATA_W = 32
);
  logic [0:3]        req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
  logic [0:DATA_W-1] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [0:DATA_W-1] out_data1,    out_data2,    out_data3,    out_data4;
  logic [0:1]        out_resp1,    out_resp2,    out_resp3,    out_resp4;

  // requester side: drives requests, observes responses
  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_data1, out_data2, out_data3, out_data4,
    input  out_resp1, out_resp2, out_resp3, out_resp4
  );

  // calculator side
  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_data1, out_data2, out_data3, out_data4,
    output out_resp1, out_resp2, out_resp3, out_resp4
  );
endinterface

// File: rtl/calc1_unit.sv
// calc1_unit: four independent fixed-latency 32-bit integer calculator ports.
// Each port takes cmd+operand1, then operand2 on the next cycle, and returns
// a one-cycle response LATENCY edges after the operand2 edge.
// Build option: define CALC1_SHIFT_EN to enable shift commands 5/6; without it
// those commands answer as invalid.

// One calculator port: request FSM, arithmetic, fixed-latency result pipe.
module calc1_lane #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [0:3]        i_cmd,
  input  logic [0:DATA_W-1] i_data,
  output logic [0:DATA_W-1] o_data,
  output logic [0:1]        o_resp
);
  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
`ifdef CALC1_SHIFT_EN
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;
  localparam int         SH_W    = $clog2(DATA_W);
`endif
  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;

  typedef enum logic {S_IDLE, S_OP2} state_t;

  state_t            r_state, w_state_nxt;
  logic              w_cap_op1, w_issue;
  logic [0:3]        r_cmd;
  logic [0:DATA_W-1] r_op1;

  logic [0:DATA_W]   w_sum;
  logic              w_borrow;
  logic [0:DATA_W-1] w_diff;
  logic [0:1]        w_resp;
  logic [0:DATA_W-1] w_res;
`ifdef CALC1_SHIFT_EN
  logic [SH_W-1:0]   w_shamt;
`endif

  // index LATENCY is the output register; index 0 is loaded on the operand2 edge
  logic [LATENCY:0]             r_vld_pipe;
  logic [LATENCY:0][0:1]        r_resp_pipe;
  logic [LATENCY:0][0:DATA_W-1] r_data_pipe;

  // request FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next state: any non-zero command opens a request, the following cycle
  // always consumes operand2 regardless of what is on the cmd input
  always_comb begin
    w_state_nxt = r_state;
    w_cap_op1   = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd != CMD_NOP) begin
          w_cap_op1   = 1'b1;
          w_state_nxt = S_OP2;
        end
      end
      S_OP2: begin
        w_issue     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // hold command and operand1 until operand2 arrives
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd <= CMD_NOP;
      r_op1 <= '0;
    end else if (w_cap_op1) begin
      r_cmd <= i_cmd;
      r_op1 <= i_data;
    end
  end

  // operand2 comes straight off the bus, so the result is formed in the
  // operand2 cycle and registered into pipe stage 0 on that edge
  assign w_sum    = {1'b0, r_op1} + {1'b0, i_data};
  assign w_borrow = (i_data > r_op1);
  assign w_diff   = r_op1 - i_data;
`ifdef CALC1_SHIFT_EN
  // shift amount is the low bits of operand2 (highest indices, big-endian)
  assign w_shamt  = i_data[DATA_W-SH_W +: SH_W];
`endif

  // arithmetic: anything not explicitly OK answers error with zero data
  always_comb begin
    w_resp = RESP_ERR;
    w_res  = '0;
    case (r_cmd)
      CMD_ADD: begin
        if (!w_sum[0]) begin
          w_resp = RESP_OK;
          w_res  = w_sum[1:DATA_W];
        end
      end
      CMD_SUB: begin
        if (!w_borrow) begin
          w_resp = RESP_OK;
          w_res  = w_diff;
        end
      end
`ifdef CALC1_SHIFT_EN
      CMD_SHL: begin
        w_resp = RESP_OK;
        w_res  = r_op1 << w_shamt;
      end
      CMD_SHR: begin
        w_resp = RESP_OK;
        w_res  = r_op1 >> w_shamt;
      end
`endif
      default: ;
    endcase
  end

  // fixed-latency result pipe; reset drops everything in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe  <= '0;
      r_resp_pipe <= '0;
      r_data_pipe <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[LATENCY-1:0],  w_issue};
      r_resp_pipe <= {r_resp_pipe[LATENCY-1:0], w_resp};
      r_data_pipe <= {r_data_pipe[LATENCY-1:0], w_res};
    end
  end

  // outputs idle at zero unless a response sits in the final stage
  assign o_resp = r_vld_pipe[LATENCY] ? r_resp_pipe[LATENCY] : RESP_NONE;
  assign o_data = (r_vld_pipe[LATENCY] && (r_resp_pipe[LATENCY] == RESP_OK))
                  ? r_data_pipe[LATENCY] : '0;
endmodule

// Top: unpack the bus into per-port lanes.
module calc1_unit #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic         c_clk,
  input  logic         reset,
  calc1_unit_if.slave  bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][0:3]        w_cmd;
  logic [NUM_LANES-1:0][0:DATA_W-1] w_data;
  logic [NUM_LANES-1:0][0:DATA_W-1] w_out_data;
  logic [NUM_LANES-1:0][0:1]        w_out_resp;

  // lane 0 = port 1
  assign w_cmd  = {bus.req4_cmd_in,  bus.req3_cmd_in,  bus.req2_cmd_in,  bus.req1_cmd_in};
  assign w_data = {bus.req4_data_in, bus.req3_data_in, bus.req2_data_in, bus.req1_data_in};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    calc1_lane #(
      .DATA_W  (DATA_W),
      .LATENCY (LATENCY)
    ) u_lane (
      .i_clk   (c_clk),
      .i_rst_n (reset),
      .i_cmd   (w_cmd[g]),
      .i_data  (w_data[g]),
      .o_data  (w_out_data[g]),
      .o_resp  (w_out_resp[g])
    );
  end

  assign bus.out_data1 = w_out_data[0];
  assign bus.out_data2 = w_out_data[1];
  assign bus.out_data3 = w_out_data[2];
  assign bus.out_data4 = w_out_data[3];
  assign bus.out_resp1 = w_out_resp[0];
  assign bus.out_resp2 = w_out_resp[1];
  assign bus.out_resp3 = w_out_resp[2];
  assign bus.out_resp4 = w_out_resp[3];
endmodule

// File: tb/tb_calc1_unit.sv
// tb_calc1_unit: scoreboard bench for calc1_unit. Stimulus pushes expected
// responses (with their due cycle) into per-port queues; a negedge monitor
// pops and compares whenever a port shows a response.
module tb_calc1_unit;
  localparam int LAT = 3;

  typedef struct {
    int          due;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t q0[$], q1[$], q2[$], q3[$];
  logic [33:0] mon_o;
  exp_t        mon_e;

  calc1_unit_if #(.DATA_W(32)) bus ();

  calc1_unit #(.DATA_W(32), .LATENCY(LAT)) dut (
    .c_clk (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // reference model: plain unsigned arithmetic on the command rules
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] s;
    case (c)
      4'd1: begin
        s = {32'd0, a} + {32'd0, b};
        if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, s[31:0]};
      end
      4'd2: begin
        if (b > a) return {2'd2, 32'd0};
        return {2'd1, a - b};
      end
`ifdef CALC1_SHIFT_EN
      4'd5: return {2'd1, a << b[4:0]};
      4'd6: return {2'd1, a >> b[4:0]};
`endif
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [33:0] get_out(input int p);
    case (p)
      0: return {bus.out_resp1, bus.out_data1};
      1: return {bus.out_resp2, bus.out_data2};
      2: return {bus.out_resp3, bus.out_data3};
      default: return {bus.out_resp4, bus.out_data4};
    endcase
  endfunction

  function automatic int qsize(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic int qfront_due(input int p);
    case (p)
      0: return q0[0].due;
      1: return q1[0].due;
      2: return q2[0].due;
      default: return q3[0].due;
    endcase
  endfunction

  function automatic exp_t qpop(input int p);
    case (p)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic push_exp(input int p, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int due);
    exp_t e;
    logic [33:0] m;
    m = model(c, a, b);
    e.due  = due;
    e.resp = m[33:32];
    e.data = m[31:0];
    case (p)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d);
    case (p)
      0: begin bus.req1_cmd_in = c; bus.req1_data_in = d; end
      1: begin bus.req2_cmd_in = c; bus.req2_data_in = d; end
      2: begin bus.req3_cmd_in = c; bus.req3_data_in = d; end
      default: begin bus.req4_cmd_in = c; bus.req4_data_in = d; end
    endcase
  endtask

  // monitor: every response must match the queue head and arrive on its due cycle
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      mon_o = get_out(p);
      if (!rst_n) begin
        chk($sformatf("reset_out_p%0d", p + 1), {30'd0, mon_o}, 64'd0);
      end else if (mon_o[33:32] != 2'd0) begin
        if (qsize(p) == 0) begin
          chk($sformatf("unexpected_resp_p%0d", p + 1), {30'd0, mon_o}, 64'd0);
        end else begin
          mon_e = qpop(p);
          chk($sformatf("due_cycle_p%0d", p + 1), 64'(cyc), 64'(mon_e.due));
          chk($sformatf("resp_data_p%0d", p + 1), {30'd0, mon_o},
              {30'd0, mon_e.resp, mon_e.data});
        end
      end else if (qsize(p) > 0 && qfront_due(p) <= cyc) begin
        mon_e = qpop(p);
        chk($sformatf("missing_resp_p%0d", p + 1), {30'd0, mon_o},
            {30'd0, mon_e.resp, mon_e.data});
      end
    end
  end

  // two-cycle request on any subset of ports (cmd 0 = port idle); call at a negedge
  task automatic issue(input logic [3:0] c[4], input logic [31:0] a[4],
                       input logic [31:0] b[4]);
    for (int p = 0; p < 4; p++) begin
      set_port(p, c[p], a[p]);
      if (c[p] != 4'd0) push_exp(p, c[p], a[p], b[p], cyc + 2 + LAT);
    end
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      // cmd is don't-care while operand2 is taken
      if (c[p] != 4'd0) set_port(p, 4'($urandom), b[p]);
      else              set_port(p, 4'd0, $urandom);
    end
    @(negedge clk);
    for (int p = 0; p < 4; p++) set_port(p, 4'd0, $urandom);
  endtask

  task automatic req1(input int p, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b);
    logic [3:0]  cc[4];
    logic [31:0] aa[4], bb[4];
    for (int i = 0; i < 4; i++) begin cc[i] = 4'd0; aa[i] = 32'd0; bb[i] = 32'd0; end
    cc[p] = c; aa[p] = a; bb[p] = b;
    issue(cc, aa, bb);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'hFFFF_FFFF - $urandom_range(0, 15);
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rnd_cmd();
    case ($urandom_range(0, 7))
      0, 1: return 4'd0;
      2: return 4'd1;
      3: return 4'd2;
      4: return 4'd5;
      5: return 4'd6;
      default: return 4'($urandom_range(1, 15));
    endcase
  endfunction

  initial begin
    logic [3:0]  cc[4];
    logic [31:0] aa[4], bb[4];
    for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'd0);

    // reset asserted between clock edges must clear outputs at once
    #1 rst_n = 1'b0;
    #1;
    for (int p = 0; p < 4; p++)
      chk($sformatf("async_reset_p%0d", p + 1), {30'd0, get_out(p)}, 64'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases on port 1
    req1(0, 4'd1, 32'h1,         32'h1FF_FFFF);
    req1(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    req1(0, 4'd1, 32'h0,         32'h0);
    req1(0, 4'd1, 32'hFFFF_FFFF, 32'h1);
    req1(0, 4'd2, 32'h1,         32'hF);
    req1(0, 4'd2, 32'hF,         32'hF);
    req1(0, 4'd3, $urandom,      $urandom);
    repeat (LAT + 3) @(negedge clk);
    // isolated error pulse: any second cycle of response shows as unexpected
    req1(0, 4'd4, $urandom,      $urandom);
    repeat (LAT + 3) @(negedge clk);
    req1(0, 4'd5, 32'h1,         32'd31);
    req1(0, 4'd6, 32'h8000_0000, 32'd35);

    // back-to-back sweep: x + 0 == x
    for (int x = 1; x <= 9999; x++) req1(0, 4'd1, 32'(x), 32'd0);

    // random mixed traffic on all ports
    for (int it = 0; it < 400; it++) begin
      for (int p = 0; p < 4; p++) begin
        cc[p] = rnd_cmd(); aa[p] = rnd_val(); bb[p] = rnd_val();
      end
      issue(cc, aa, bb);
    end
    repeat (LAT + 4) @(negedge clk);

    // simultaneous distinct adds on all ports
    cc = '{4'd1, 4'd1, 4'd1, 4'd1};
    aa = '{32'd10, 32'd200, 32'd3000, 32'd40000};
    bb = '{32'd5, 32'd6, 32'd7, 32'd8};
    issue(cc, aa, bb);
    repeat (LAT) @(negedge clk);
    // batch 1 responses are on the outputs now; start batch 2 and kill it
    for (int p = 0; p < 4; p++) set_port(p, 4'd1, 32'(p + 77));
    #2 rst_n = 1'b0;
    #1;
    for (int p = 0; p < 4; p++)
      chk($sformatf("midreq_reset_p%0d", p + 1), {30'd0, get_out(p)}, 64'd0);
    @(negedge clk);
    for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'(p + 99));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 6) @(negedge clk);

    for (int p = 0; p < 4; p++)
      chk($sformatf("queue_drained_p%0d", p + 1), 64'(qsize(p)), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
